half_adder: RTL and testbench
=============================

# half_adder

Bit-parallel half adder forming the lowest arithmetic primitive of the ALU datapath. Each lane produces the sum (XOR) and carry (AND) of two operand bits combinationally. The block also provides a registered, valid-qualified copy of the result for pipelined consumers, and an optional per-vector carry population count.

## Interface

Parameters:
- WIDTH, default 1: number of independent half-adder lanes (1..64).

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears all registers immediately on assertion, released synchronously to clk.
- s  output  WIDTH  combinational sum, s[i] = a[i] ^ b[i].
- c  output  WIDTH  combinational carry, c[i] = a[i] & b[i].
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  operands valid this cycle; qualifies capture into the output register.
- s_q  output  WIDTH  registered sum.
- c_q  output  WIDTH  registered carry.
- out_valid  output  1  s_q/c_q/carry_cnt hold a result captured on the previous edge.
- carry_cnt  output  $clog2(WIDTH+1)  registered count of set bits in c_q (minimum width 1).

Positional port order: s, c, a, b, then clk, rst_n, in_valid, s_q, c_q, out_valid, carry_cnt. The first four positions are fixed so that a positional instance (s, c, a, b) connects correctly.

## Operation

- Combinational path:
  - s and c are pure functions of a and b.
  - No dependence on clk, rst_n or in_valid.
  - Valid even while reset is asserted.
- Lanes are fully independent. There is no carry propagation between lanes.
- Per-lane truth table:
  - a=0, b=0 -> s=0, c=0
  - a=0, b=1 -> s=1, c=0
  - a=1, b=0 -> s=1, c=0
  - a=1, b=1 -> s=0, c=1
- Registered path, on each rising edge with rst_n high:
  - in_valid=1: s_q <= a^b, c_q <= a&b, carry_cnt <= popcount(a&b), out_valid <= 1.
  - in_valid=0: s_q, c_q and carry_cnt hold their values; out_valid <= 0.
- Consumers sample s_q/c_q/carry_cnt only when out_valid=1.
- No backpressure: the block accepts one vector every cycle.
- Invariant: s_q & c_q == 0 at all times, since no lane can have both sum and carry set.
- X or Z on a/b propagates to s/c. No X-masking is required.

## Timing

- s, c: zero-cycle latency, combinational, no internal state.
- s_q, c_q, carry_cnt, out_valid: one-cycle latency from the in_valid=1 sample edge.
- Reset values: s_q=0, c_q=0, carry_cnt=0, out_valid=0.
- Reset takes effect asynchronously, without waiting for a clock edge.
- Reset asserted mid-stream:
  - Any in-flight vector is discarded.
  - out_valid is 0 on the first edge after release unless in_valid=1 at that edge.
- Back-to-back in_valid=1: a new result every cycle, with out_valid held continuously high.

## Configuration

- HALF_ADDER_CARRY_CNT_EN defined:
  - The popcount adder tree and the carry_cnt register are built.
  - carry_cnt behaves as specified above.
- HALF_ADDER_CARRY_CNT_EN undefined:
  - The popcount logic and register are omitted.
  - carry_cnt is tied to constant 0.
  - The port list is unchanged.
  - All other behaviour is identical.

## Test plan

- WIDTH=1, combinational only, clk idle: apply a,b = 00, 01, 10, 11 with 1 time unit of settle each. Require (s,c) = (0,0), (1,0), (1,0), (0,1). Abort on the first mismatch.
- Reset check: hold rst_n=0 with a=1, b=1. Require s=0, c=1 while s_q=0, c_q=0, out_valid=0, carry_cnt=0.
- WIDTH=8, macro defined: a=8'hF0, b=8'hCC, in_valid=1 for one edge. The next cycle requires s_q=8'h3C, c_q=8'hC0, carry_cnt=2, out_valid=1. The following cycle, with in_valid=0, requires out_valid=0 and s_q still 8'h3C.
- WIDTH=8, all ones: a=b=8'hFF streamed for 3 consecutive cycles. Require c_q=8'hFF, s_q=0, carry_cnt=8, and out_valid high for 3 cycles.
- Mid-stream async reset: assert rst_n=0 between edges during streaming. Require all registered outputs to reach 0 before the next edge.
- Macro undefined, WIDTH=8, a=b=8'hFF: require carry_cnt=0 while c_q=8'hFF.

Source files
------------

// File: rtl/half_adder.sv
// Bit-parallel half adder with a registered, valid-qualified result copy.
// Each lane forms sum = a ^ b and carry = a & b combinationally; the same
// result is captured into s_q/c_q when in_valid is high.
// Optional feature macro: HALF_ADDER_CARRY_CNT_EN builds the carry population
// count register; when undefined, carry_cnt is tied to zero.
module half_adder #(
  parameter  int unsigned WIDTH = 1,
  localparam int unsigned CntW  = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1)
) (
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s_q,
  output logic [WIDTH-1:0] c_q,
  output logic             out_valid,
  output logic [CntW-1:0]  carry_cnt
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_c;
  logic             r_valid;

  // Lanes are independent: no carry ripples between bit positions.
  assign w_sum   = a ^ b;
  assign w_carry = a & b;

  assign s = w_sum;
  assign c = w_carry;

  // Result register: captures on in_valid, otherwise holds the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s <= '0;
      r_c <= '0;
    end else if (in_valid) begin
      r_s <= w_sum;
      r_c <= w_carry;
    end
  end

  // Valid flag: high only for the cycle following an accepted vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
    end
  end

  assign s_q       = r_s;
  assign c_q       = r_c;
  assign out_valid = r_valid;

`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [CntW-1:0] w_pop;
  logic [CntW-1:0] r_cnt;

  // Population count of the incoming carry vector, so the registered count
  // lines up with c_q on the same edge.
  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + CntW'(w_carry[i]);
    end
  end

  // Count register shares the capture qualifier with s_q/c_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (in_valid) begin
      r_cnt <= w_pop;
    end
  end

  assign carry_cnt = r_cnt;
`else
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: a WIDTH=1 instance for the lane truth
// table and a WIDTH=8 instance for the registered path, both compared against
// a per-lane arithmetic reference model (sum of two bits -> sum/carry).
module tb_half_adder;

  localparam int unsigned W8  = 8;
  localparam int unsigned CW8 = $clog2(W8 + 1);

  logic            clk;
  logic            clk1;
  logic            rst_n;
  logic            in_valid;
  logic [W8-1:0]   a, b;
  logic [W8-1:0]   s, c, s_q, c_q;
  logic            out_valid;
  logic [CW8-1:0]  carry_cnt;

  logic            a1, b1, in_valid1;
  logic            s1, c1, s_q1, c_q1, out_valid1;
  logic            carry_cnt1;

  int tests = 0;
  int fails = 0;

  // Reference model state for the registered path of the 8-lane instance
  logic [W8-1:0]  m_s, m_c;
  logic [CW8-1:0] m_cnt;
  logic           m_v;

  half_adder #(.WIDTH(W8)) u_dut8 (
    .s(s), .c(c), .a(a), .b(b), .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .s_q(s_q), .c_q(c_q), .out_valid(out_valid), .carry_cnt(carry_cnt)
  );

  half_adder #(.WIDTH(1)) u_dut1 (
    .s(s1), .c(c1), .a(a1), .b(b1), .clk(clk1), .rst_n(rst_n), .in_valid(in_valid1),
    .s_q(s_q1), .c_q(c_q1), .out_valid(out_valid1), .carry_cnt(carry_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane-by-lane arithmetic: the two operand bits add to 0, 1 or 2.
  task automatic model_add(input logic [W8-1:0] x, input logic [W8-1:0] y,
                           output logic [W8-1:0] ms, output logic [W8-1:0] mc,
                           output int cnt);
    cnt = 0;
    for (int i = 0; i < int'(W8); i++) begin
      int total;
      total = int'(x[i]) + int'(y[i]);
      ms[i] = (total % 2) == 1;
      mc[i] = (total / 2) == 1;
      cnt += total / 2;
    end
  endtask

  function automatic logic [CW8-1:0] exp_cnt(input int cnt);
`ifdef HALF_ADDER_CARRY_CNT_EN
    return CW8'(cnt);
`else
    return '0;
`endif
  endfunction

  // One rising edge; model updates from the inputs held across it, then outputs
  // are sampled 1 time unit later.
  task automatic tick();
    logic [W8-1:0] ms, mc;
    int cnt;
    @(posedge clk);
    if (rst_n) begin
      if (in_valid) begin
        model_add(a, b, ms, mc, cnt);
        m_s   = ms;
        m_c   = mc;
        m_cnt = exp_cnt(cnt);
        m_v   = 1'b1;
      end else begin
        m_v = 1'b0;
      end
    end
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".s_q"}, 64'(s_q), 64'(m_s));
    check({tag, ".c_q"}, 64'(c_q), 64'(m_c));
    check({tag, ".cnt"}, 64'(carry_cnt), 64'(m_cnt));
    check({tag, ".ov"},  64'(out_valid), 64'(m_v));
    check({tag, ".inv"}, 64'(s_q & c_q), 64'(0));
  endtask

  task automatic check_comb(input string tag);
    logic [W8-1:0] ms, mc;
    int cnt;
    model_add(a, b, ms, mc, cnt);
    check({tag, ".s"}, 64'(s), 64'(ms));
    check({tag, ".c"}, 64'(c), 64'(mc));
  endtask

  initial begin
    logic [1:0] pat;
    logic [W8-1:0] ms, mc;
    int cnt;

    // Reset asserted, operands all ones: combinational path still live.
    rst_n = 1'b0; in_valid = 1'b0; a = 8'hFF; b = 8'hFF;
    clk1 = 1'b0; in_valid1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    m_s = '0; m_c = '0; m_cnt = '0; m_v = 1'b0;
    #2;
    check("rst.s1", 64'(s1), 64'(0));
    check("rst.c1", 64'(c1), 64'(1));
    check("rst.s_q1", 64'(s_q1), 64'(0));
    check("rst.c_q1", 64'(c_q1), 64'(0));
    check("rst.ov1", 64'(out_valid1), 64'(0));
    check("rst.cnt1", 64'(carry_cnt1), 64'(0));
    check_comb("rst8");
    check_regs("rst8");

    // WIDTH=1 truth table, clock idle.
    for (int i = 0; i < 4; i++) begin
      pat = 2'(i);
      a1 = pat[1]; b1 = pat[0];
      #1;
      check("tt.s", 64'(s1), 64'((int'(a1) + int'(b1)) % 2));
      check("tt.c", 64'(c1), 64'((int'(a1) + int'(b1)) / 2));
    end
    if (fails != 0) begin
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "FAIL truth table mismatch, aborting");
    end

    // Release reset away from the rising edge.
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector F0/CC, then an idle cycle.
    a = 8'hF0; b = 8'hCC; in_valid = 1'b1;
    tick();
    check("dir.s_q", 64'(s_q), 64'(8'h3C));
    check("dir.c_q", 64'(c_q), 64'(8'hC0));
    check("dir.cnt", 64'(carry_cnt), 64'(exp_cnt(2)));
    check("dir.ov", 64'(out_valid), 64'(1));
    in_valid = 1'b0; a = 8'h00; b = 8'h00;
    tick();
    check("idle.ov", 64'(out_valid), 64'(0));
    check("idle.s_q", 64'(s_q), 64'(8'h3C));
    check_regs("idle");

    // All-ones stream for three consecutive cycles.
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ones.c_q", 64'(c_q), 64'(8'hFF));
      check("ones.s_q", 64'(s_q), 64'(0));
      check("ones.cnt", 64'(carry_cnt), 64'(exp_cnt(8)));
      check("ones.ov", 64'(out_valid), 64'(1));
    end

    // Randomized vectors on both instances.
    for (int i = 0; i < 60; i++) begin
      a = W8'($urandom); b = W8'($urandom); in_valid = ($urandom_range(3) != 0);
      a1 = 1'($urandom); b1 = 1'($urandom);
      #1;
      check_comb("rnd");
      check("rnd.s1", 64'(s1), 64'((int'(a1) + int'(b1)) % 2));
      check("rnd.c1", 64'(c1), 64'((int'(a1) + int'(b1)) / 2));
      tick();
      check_regs("rnd");
    end

    // Mid-stream asynchronous reset between edges.
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    tick();
    check_regs("pre_rst");
    a = 8'h5A; b = 8'hF3;
    #2;
    rst_n = 1'b0;
    m_s = '0; m_c = '0; m_cnt = '0; m_v = 1'b0;
    #1;
    check_regs("async_rst");
    tick();
    check_regs("held_rst");
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    check_regs("post_rst_idle");
    in_valid = 1'b1;
    model_add(a, b, ms, mc, cnt);
    tick();
    check("post_rst.c_q", 64'(c_q), 64'(mc));
    check("post_rst.cnt", 64'(carry_cnt), 64'(exp_cnt(cnt)));
    check_regs("post_rst_cap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
